// File: rtl/byte_block_packer.sv
// rtl/byte_block_packer.sv - byte stream to NBYTES-wide block packer with flush
// Bytes fill lanes in arrival order; a full block or in_last moves it to the output register.
module byte_block_packer #(
    parameter int NBYTES    = 16,
    parameter int BYTE_W    = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [BYTE_W-1:0]                   in_data_i,
    input  logic                                in_last_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [NBYTES*BYTE_W-1:0]            out_block_o,
    output logic [$clog2(NBYTES+1)-1:0]         out_count_o,
    output logic                                out_partial_o
);

    localparam int CW = $clog2(NBYTES + 1);
    localparam int BW = NBYTES * BYTE_W;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] acc_q, acc_d;
    logic [BW-1:0] blk_q, blk_d;
    logic [CW-1:0] count_q, count_d;
    logic          partial_q, partial_d;
    logic          valid_q, valid_d;

    logic          accept;
    logic          complete;
    logic [CW-1:0] lane;
    logic [BW-1:0] merged;

    assign in_ready_o = !rst_i && (!valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign complete   = accept && (in_last_i || (cnt_q == CW'(NBYTES - 1)));

    // acc only ever holds lanes written in the current block, so unwritten lanes stay zero
    always_comb begin
        lane   = LSB_FIRST ? cnt_q : (CW'(NBYTES - 1) - cnt_q);
        merged = acc_q;
        merged[int'(lane)*BYTE_W +: BYTE_W] = in_data_i;
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        blk_d     = blk_q;
        count_d   = count_q;
        partial_d = partial_q;
        valid_d   = valid_q;
        if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            if (complete) begin
                blk_d     = merged;
                count_d   = cnt_q + 1'b1;
                partial_d = (cnt_q + 1'b1) < CW'(NBYTES);
                valid_d   = 1'b1;
                cnt_d     = '0;
                acc_d     = '0;
            end else begin
                acc_d = merged;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            blk_q     <= '0;
            count_q   <= '0;
            partial_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            blk_q     <= blk_d;
            count_q   <= count_d;
            partial_q <= partial_d;
            valid_q   <= valid_d;
        end
    end

    assign out_valid_o   = valid_q;
    assign out_block_o   = blk_q;
    assign out_count_o   = count_q;
    assign out_partial_o = partial_q;

endmodule

// File: tb/tb_byte_block_packer.sv
// tb/tb_byte_block_packer.sv - randomized and directed checks of byte_block_packer against a queue model
module tb_byte_block_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;

    logic         rdy_m, val_m, part_m;
    logic [127:0] blk_m;
    logic [4:0]   cnt_m;
    logic         rdy_l, val_l, part_l;
    logic [127:0] blk_l;
    logic [4:0]   cnt_l;

    logic         v4 = 1'b0;
    logic [7:0]   d4 = '0;
    logic         rdy4, val4, part4;
    logic [31:0]  blk4;
    logic [2:0]   cnt4;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    byte_block_packer dut_msb (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_m),
        .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(val_m),
        .out_ready_i(out_ready), .out_block_o(blk_m), .out_count_o(cnt_m),
        .out_partial_o(part_m)
    );

    byte_block_packer #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_l),
        .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(val_l),
        .out_ready_i(out_ready), .out_block_o(blk_l), .out_count_o(cnt_l),
        .out_partial_o(part_l)
    );

    byte_block_packer #(.NBYTES(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v4), .in_ready_o(rdy4),
        .in_data_i(d4), .in_last_i(1'b0), .out_valid_o(val4),
        .out_ready_i(1'b1), .out_block_o(blk4), .out_count_o(cnt4),
        .out_partial_o(part4)
    );

    // Reference: the current block is a plain queue of bytes; blocks are laid out from it on completion
    logic [7:0]   cur[$];
    bit           m_valid = 0;
    logic [127:0] m_msb = '0, m_lsb = '0;
    int           m_count = 0;
    bit           m_partial = 0;

    function automatic bit m_ready();
        return !rst && (!m_valid || out_ready);
    endfunction

    function automatic logic [127:0] layout(bit lsb);
        logic [127:0] b = '0;
        for (int i = 0; i < cur.size(); i++) begin
            if (lsb) b[8*i +: 8] = cur[i];
            else     b[127-8*i -: 8] = cur[i];
        end
        return b;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cur.delete();
            m_valid = 0; m_msb = '0; m_lsb = '0; m_count = 0; m_partial = 0;
        end else begin
            bit acc;
            acc = in_valid && m_ready();
            if (m_valid && out_ready) m_valid = 0;
            if (acc) begin
                cur.push_back(in_data);
                if (cur.size() == 16 || in_last) begin
                    m_msb = layout(0);
                    m_lsb = layout(1);
                    m_count = cur.size();
                    m_partial = (cur.size() < 16);
                    m_valid = 1;
                    cur.delete();
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("msb_ctrl", {124'd0, rdy_m, val_m, part_m, 1'b0},
                {124'd0, m_ready(), m_valid, m_partial, 1'b0});
            chk("msb_count", {123'd0, cnt_m}, 128'(m_count));
            chk("msb_block", blk_m, m_msb);
            chk("lsb_ctrl", {124'd0, rdy_l, val_l, part_l, 1'b0},
                {124'd0, m_ready(), m_valid, m_partial, 1'b0});
            chk("lsb_count", {123'd0, cnt_l}, 128'(m_count));
            chk("lsb_block", blk_l, m_lsb);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input bit last);
        in_valid = 1'b1; in_data = d; in_last = last;
        step();
    endtask

    initial begin
        chk_en = 1'b1;
        step();
        step();
        chk("reset_outputs", {blk_m, 1'b0} >> 1, '0);
        chk("reset_flags", {125'd0, val_m, part_m, rdy_m}, '0);
        chk("reset_count", {123'd0, cnt_m}, '0);
        rst = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 16; i++) drive(8'(i * 17), 1'b0);
        chk("cont_msb", blk_m, 128'h00112233445566778899aabbccddeeff);
        chk("cont_lsb", blk_l, 128'hffeeddccbbaa99887766554433221100);
        chk("cont_count", {122'd0, part_m, cnt_m}, {122'd0, 1'b0, 5'd16});
        chk("model_cont", m_msb, 128'h00112233445566778899aabbccddeeff);

        for (int i = 1; i <= 5; i++) drive(8'(i), i == 5);
        chk("flush_msb", blk_m, 128'h01020304050000000000000000000000);
        chk("flush_lsb", blk_l, 128'h00000000000000000000000504030201);
        chk("flush_count", {122'd0, part_m, cnt_m}, {122'd0, 1'b1, 5'd5});

        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h10; in_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_ready", {127'd0, rdy_m}, '0);
            chk("stall_block", blk_m, 128'h01020304050000000000000000000000);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) drive(8'(8'h10 + i), 1'b0);
        chk("stall_next_block", blk_m, 128'h101112131415161718191a1b1c1d1e1f);

        for (int i = 0; i < 7; i++) drive(8'(8'h50 + i), 1'b0);
        rst = 1'b1;
        step();
        chk("midrst_block", blk_m, '0);
        chk("midrst_flags", {125'd0, val_m, part_m, rdy_m}, '0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) drive(8'(8'ha0 + i), 1'b0);
        chk("midrst_after", blk_m, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
        in_valid = 1'b0;

        v4 = 1'b1;
        d4 = 8'hde; step();
        d4 = 8'had; step();
        d4 = 8'hbe; step();
        d4 = 8'hef; step();
        v4 = 1'b0;
        chk("n4_block", {96'd0, blk4}, {96'd0, 32'hdeadbeef});
        chk("n4_count", {123'd0, val4, part4, cnt4}, {123'd0, 1'b1, 1'b0, 3'd4});

        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
